ldpc_wb_multich_dec_bridge: RTL

Wishbone-slave staging bridge between the management SoC and the ldpcEncDec decoder core. It holds NUM_CH independent NN-bit codeword input buffers and result buffers, which the SoC loads and reads 32 bits at a time. Channels with a pending start are arbitrated round-robin onto a single decoder port, with a timeout watchdog and a maskable completion interrupt. It replaces the wide parallel P_*/PO_* pin bundle with a scalable, memory-mapped, multi-channel interface.

---
 rtl/ldpc_bridge_pkg.sv | 34 +++
 rtl/ldpc_rr_arbiter.sv | 32 +++
 rtl/ldpc_wb_multich_dec_bridge.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ldpc_bridge_pkg.sv
// Shared definitions for the ldpc decoder Wishbone bridge:
// register map offsets, field positions and the arbiter state type.
package ldpc_bridge_pkg;

  localparam logic [11:0] OFF_CTRL   = 12'h000;
  localparam logic [11:0] OFF_STATUS = 12'h004;
  localparam logic [11:0] OFF_ERR    = 12'h008;

  // buffer windows expressed in 64-byte channel blocks
  localparam logic [5:0] BLK_IN  = 6'h04;
  localparam logic [5:0] BLK_RES = 6'h08;

  localparam int CTRL_IEN  = 8;
  localparam int CTRL_SCLR = 16;

  localparam int ST_PEND = 0;
  localparam int ST_BUSY = 8;
  localparam int ST_DONE = 16;
  localparam int ST_PASS = 24;

  localparam int ERR_TO  = 0;
  localparam int ERR_WWB = 8;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2
  } arb_state_e;

  function automatic int wpc(input int nn);
    return (nn + 31) / 32;
  endfunction

endpackage

// File: rtl/ldpc_rr_arbiter.sv
// Round-robin pick: lowest requesting channel at or after ptr+1,
// wrapping modulo NUM_CH.
module ldpc_rr_arbiter
  import ldpc_bridge_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CW     = 2
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CW-1:0]     ptr,
  output logic [NUM_CH-1:0] gnt,
  output logic [CW-1:0]     idx,
  output logic              any
);

  always_comb begin
    int c;
    c   = 0;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int i = 1; i <= NUM_CH; i++) begin
      c = (int'(ptr) + i) % NUM_CH;
      if (!any && req[c]) begin
        any    = 1'b1;
        gnt[c] = 1'b1;
        idx    = CW'(c);
      end
    end
  end

endmodule

// File: rtl/ldpc_wb_multich_dec_bridge.sv
// Wishbone slave staging NUM_CH codeword buffers in front of a single
// ldpc decoder port, with round-robin issue, watchdog and interrupt.
module ldpc_wb_multich_dec_bridge
  import ldpc_bridge_pkg::*;
#(
  parameter int          NN          = 208,
  parameter int          NUM_CH      = 4,
  parameter int          TIMEOUT_CYC = 65535,
  parameter logic [31:0] BASE_ADR    = 32'h3000_0000
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          wbs_stb_i,
  input  logic          wbs_cyc_i,
  input  logic          wbs_we_i,
  input  logic [3:0]    wbs_sel_i,
  input  logic [31:0]   wbs_adr_i,
  input  logic [31:0]   wbs_dat_i,
  output logic          wbs_ack_o,
  output logic [31:0]   wbs_dat_o,
  output logic [NN-1:0] dec_y_o,
  output logic          dec_start_o,
  input  logic          dec_valid_i,
  input  logic [NN-1:0] dec_y_i,
  input  logic          dec_pass_i,
  output logic          irq_o
);

  localparam int WPC = wpc(NN);
  localparam int CW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int WW  = (WPC > 1) ? $clog2(WPC) : 1;
  localparam int TW  = $clog2(TIMEOUT_CYC + 1);
  localparam logic [5:0]  NCH6  = 6'(NUM_CH);
  localparam logic [4:0]  WPC5  = 5'(WPC);
  localparam logic [31:0] LMASK = (NN % 32 == 0) ? 32'hFFFF_FFFF
                                : (32'h1 << (NN % 32)) - 32'h1;

  logic [WPC*32-1:0] in_buf  [NUM_CH];
  logic [WPC*32-1:0] res_buf [NUM_CH];
  logic [WPC*32-1:0] y_pad;

  logic [NUM_CH-1:0] pending, busy, done, pass, irq_en, err_to, err_wwb;
  logic [NUM_CH-1:0] pending_nx, busy_nx, done_nx, pass_nx;
  logic [NUM_CH-1:0] err_to_nx, err_wwb_nx;
  logic [NUM_CH-1:0] gnt, cur_oh, in_oh;
  logic [CW-1:0]     rr_ptr, cur_ch, gnt_idx, in_ch, res_ch;
  logic              gnt_any, grant, cap, tmo, fin;
  logic [TW-1:0]     timer;
  arb_state_e        state, state_nx;

  logic        req, hit, wr, rd, unused;
  logic [11:0] off;
  logic [5:0]  blk, in_blk, res_blk;
  logic [WW-1:0] wv;
  logic        wi_ok, in_hit, res_hit, is_ctrl, is_stat, is_err;
  logic        blocked, in_wr, wwb, ctrl_wr, stat_wr, err_wr, sclr;
  logic [31:0] bmask, wmask, in_old, in_new, rdata;

  assign req     = wbs_stb_i & wbs_cyc_i & ~wbs_ack_o;
  assign hit     = wbs_adr_i[31:12] == BASE_ADR[31:12];
  assign wr      = req & hit & wbs_we_i;
  assign rd      = req & hit & ~wbs_we_i;
  assign off     = wbs_adr_i[11:0];
  assign unused  = ^off[1:0];
  assign blk     = off[11:6];
  assign in_blk  = blk - BLK_IN;
  assign res_blk = blk - BLK_RES;
  assign wv      = off[2 +: WW];
  assign wi_ok   = {1'b0, off[5:2]} < WPC5;
  assign in_ch   = in_blk[CW-1:0];
  assign res_ch  = res_blk[CW-1:0];

  // result window wins should the two windows ever overlap
  assign res_hit = (blk >= BLK_RES) && (res_blk < NCH6) && wi_ok;
  assign in_hit  = (blk >= BLK_IN) && (in_blk < NCH6) && wi_ok && !res_hit;
  assign is_ctrl = off == OFF_CTRL;
  assign is_stat = off == OFF_STATUS;
  assign is_err  = off == OFF_ERR;

  assign blocked = pending[in_ch] | busy[in_ch];
  assign in_wr   = wr & in_hit & ~blocked;
  assign wwb     = wr & in_hit & blocked;
  assign ctrl_wr = wr & is_ctrl;
  assign stat_wr = wr & is_stat;
  assign err_wr  = wr & is_err;
  assign sclr    = ctrl_wr & wbs_sel_i[2] & wbs_dat_i[CTRL_SCLR];

  assign bmask = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}},
                  {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
  assign wmask  = (wv == WW'(WPC - 1)) ? LMASK : 32'hFFFF_FFFF;
  assign in_old = in_buf[in_ch][{wv, 5'b0} +: 32];
  assign in_new = ((in_old & ~bmask) | (wbs_dat_i & bmask)) & wmask;

  assign grant  = (state == ARB_IDLE) && gnt_any && !sclr;
  assign cap    = (state == ARB_WAIT) && dec_valid_i && !sclr;
  assign tmo    = (state == ARB_WAIT) && !dec_valid_i && !sclr
                  && (timer == TW'(TIMEOUT_CYC - 1));
  assign fin    = cap | tmo;
  assign cur_oh = NUM_CH'(1) << cur_ch;
  assign in_oh  = NUM_CH'(1) << in_ch;

  ldpc_rr_arbiter #(.NUM_CH(NUM_CH), .CW(CW)) u_arb (
    .req (pending),
    .ptr (rr_ptr),
    .gnt (gnt),
    .idx (gnt_idx),
    .any (gnt_any)
  );

  always_comb begin
    y_pad         = '0;
    y_pad[NN-1:0] = dec_y_i;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state <= ARB_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (sclr) begin
      state_nx = ARB_IDLE;
    end else begin
      unique case (state)
        ARB_IDLE:  if (gnt_any) state_nx = ARB_ISSUE;
        ARB_ISSUE: state_nx = ARB_WAIT;
        ARB_WAIT:  if (fin) state_nx = ARB_IDLE;
        default:   state_nx = ARB_IDLE;
      endcase
    end
  end

  always_comb begin
    dec_start_o = (state == ARB_ISSUE);
  end

  always_comb begin
    pending_nx = pending;
    busy_nx    = busy;
    done_nx    = done;
    pass_nx    = pass;
    err_to_nx  = err_to;
    err_wwb_nx = err_wwb;
    if (ctrl_wr && wbs_sel_i[0])
      pending_nx = pending | (wbs_dat_i[NUM_CH-1:0] & ~(pending | busy));
    if (grant) begin
      pending_nx = pending_nx & ~gnt;
      busy_nx    = busy | gnt;
    end
    if (stat_wr && wbs_sel_i[2])
      done_nx = done & ~wbs_dat_i[ST_DONE +: NUM_CH];
    if (err_wr && wbs_sel_i[0])
      err_to_nx = err_to & ~wbs_dat_i[ERR_TO +: NUM_CH];
    if (err_wr && wbs_sel_i[1])
      err_wwb_nx = err_wwb & ~wbs_dat_i[ERR_WWB +: NUM_CH];
    if (wwb)
      err_wwb_nx = err_wwb_nx | in_oh;
    // hardware completion is applied after the W1C so a set wins
    if (fin) begin
      done_nx = done_nx | cur_oh;
      busy_nx = busy_nx & ~cur_oh;
      pass_nx = (cap && dec_pass_i) ? (pass | cur_oh) : (pass & ~cur_oh);
    end
    if (tmo)
      err_to_nx = err_to_nx | cur_oh;
    if (sclr) begin
      pending_nx = '0;
      busy_nx    = '0;
      done_nx    = '0;
      pass_nx    = '0;
      err_to_nx  = '0;
      err_wwb_nx = '0;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      pending <= '0;
      busy    <= '0;
      done    <= '0;
      pass    <= '0;
      err_to  <= '0;
      err_wwb <= '0;
      irq_en  <= '0;
      rr_ptr  <= CW'(NUM_CH - 1);
      cur_ch  <= '0;
      timer   <= '0;
      dec_y_o <= '0;
      irq_o   <= 1'b0;
    end else begin
      pending <= pending_nx;
      busy    <= busy_nx;
      done    <= done_nx;
      pass    <= pass_nx;
      err_to  <= err_to_nx;
      err_wwb <= err_wwb_nx;
      if (ctrl_wr && wbs_sel_i[1])
        irq_en <= wbs_dat_i[CTRL_IEN +: NUM_CH];
      if (grant) begin
        cur_ch  <= gnt_idx;
        dec_y_o <= in_buf[gnt_idx][NN-1:0];
      end
      if (fin)
        rr_ptr <= cur_ch;
      timer <= (state == ARB_WAIT) ? timer + TW'(1) : '0;
      irq_o <= |(done & irq_en) | |err_to | |err_wwb;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (in_wr)
      in_buf[in_ch][{wv, 5'b0} +: 32] <= in_new;
    if (cap)
      res_buf[cur_ch] <= y_pad;
  end

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      is_ctrl: rdata[CTRL_IEN +: NUM_CH] = irq_en;
      is_stat: begin
        rdata[ST_PEND +: NUM_CH] = pending;
        rdata[ST_BUSY +: NUM_CH] = busy;
        rdata[ST_DONE +: NUM_CH] = done;
        rdata[ST_PASS +: NUM_CH] = pass;
      end
      is_err: begin
        rdata[ERR_TO  +: NUM_CH] = err_to;
        rdata[ERR_WWB +: NUM_CH] = err_wwb;
      end
      in_hit:  rdata = in_buf[in_ch][{wv, 5'b0} +: 32];
      res_hit: rdata = res_buf[res_ch][{wv, 5'b0} +: 32];
      default: ;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
    end else begin
      wbs_ack_o <= req & hit;
      if (rd)
        wbs_dat_o <= rdata;
    end
  end

endmodule
